// File: rtl/morph_pkg.sv
// Shared helpers for the streaming morphology chain (erosion/dilation):
// pixel class values, border test, counter widths and the stream FSM states.
package morph_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef enum logic {
    STREAM,
    FLUSH
  } morph_state_e;

  function automatic logic [MAX_DATA_WIDTH-1:0] bg_value(
    input int unsigned background_color,
    input int unsigned data_width
  );
    logic [MAX_DATA_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < data_width) v[i] = (background_color != 0);
    end
    return v;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] fg_value(
    input int unsigned background_color,
    input int unsigned data_width
  );
    return bg_value((background_color == 0) ? 1 : 0, data_width);
  endfunction

  function automatic logic is_border(
    input int unsigned col,
    input int unsigned row,
    input int unsigned width,
    input int unsigned height
  );
    return (row == 0) || (row == height - 1) || (col == 0) || (col == width - 1);
  endfunction

  function automatic int unsigned count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/morph_line_buffer2.sv
// Two W-deep line stores giving the row-1 and row-2 taps at the current column.
module morph_line_buffer2 import morph_pkg::*; #(
  parameter int unsigned IMAGE_WIDTH = 320,
  parameter int unsigned DATA_WIDTH  = 8,
  localparam int unsigned AW = count_width(IMAGE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  shift,
  input  logic [AW-1:0]         wr_addr,
  input  logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tap1,
  output logic [DATA_WIDTH-1:0] tap2
);

  logic [DATA_WIDTH-1:0] line0 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] line1 [IMAGE_WIDTH];

  // Synchronous read is issued one cycle ahead at the column about to be
  // written, so the taps hold the pre-write contents when the write happens.
  always_ff @(posedge clk) begin
    if (shift) begin
      line0[wr_addr] <= din;
      line1[wr_addr] <= tap1;
    end
    tap1 <= line0[rd_addr];
    tap2 <= line1[rd_addr];
  end

endmodule

// File: rtl/erosion_3x3_stream.sv
// Streaming 3x3 binary erosion: one output per input in raster order,
// border centres forced to background, self-flushing at end of frame.
module erosion_3x3_stream import morph_pkg::*; #(
  parameter int unsigned IMAGE_WIDTH      = 320,
  parameter int unsigned IMAGE_HEIGHT     = 464,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned BACKGROUND_COLOR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic                  pixel_out_valid,
  output logic [DATA_WIDTH-1:0] pixel_out
);

  localparam int unsigned CW = count_width(IMAGE_WIDTH);
  localparam int unsigned RW = count_width(IMAGE_HEIGHT);
  localparam int unsigned FW = count_width(IMAGE_WIDTH + 2);
  localparam logic [DATA_WIDTH-1:0] BG = DATA_WIDTH'(bg_value(BACKGROUND_COLOR, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] FG = DATA_WIDTH'(fg_value(BACKGROUND_COLOR, DATA_WIDTH));
  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMAGE_WIDTH);

  morph_state_e state;
  logic [CW-1:0] col, col_next, rd_addr, ccol, s1_ccol;
  logic [RW-1:0] row, crow, s1_crow;
  logic [FW-1:0] fcnt;
  logic [DATA_WIDTH-1:0] tap1, tap2;
  logic [2:0][2:0] win_fg;
  logic transfer, flush_beat, emit, s1_valid, s1_border;

  assign transfer   = pixel_valid & pixel_ready;
  assign flush_beat = (state == FLUSH);
  // No centre is complete until the (W+1)th transfer of the frame.
  assign emit = flush_beat |
                (transfer & ((row > RW'(1)) | ((row == RW'(1)) & (col != '0))));

  always_comb begin
    col_next = (col == COL_LAST) ? '0 : col + CW'(1);
    rd_addr  = col;
    if (rst) rd_addr = '0;
    else if (transfer) rd_addr = col_next;
  end

  assign s1_border = is_border(32'(s1_ccol), 32'(s1_crow), IMAGE_WIDTH, IMAGE_HEIGHT);

  morph_line_buffer2 #(
    .IMAGE_WIDTH(IMAGE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lines (
    .clk    (clk),
    .shift  (transfer),
    .wr_addr(col),
    .rd_addr(rd_addr),
    .din    (pixel_in),
    .tap1   (tap1),
    .tap2   (tap2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= STREAM;
      pixel_ready     <= 1'b1;
      col             <= '0;
      row             <= '0;
      ccol            <= '0;
      crow            <= '0;
      fcnt            <= '0;
      win_fg          <= '0;
      s1_valid        <= 1'b0;
      s1_ccol         <= '0;
      s1_crow         <= '0;
      pixel_out_valid <= 1'b0;
      pixel_out       <= BG;
    end else begin
      // Window keeps only the foreground match per tap; flush columns are background.
      if (transfer)
        win_fg <= {{tap2 == FG, tap1 == FG, pixel_in == FG}, win_fg[2], win_fg[1]};
      else if (flush_beat)
        win_fg <= {3'b000, win_fg[2], win_fg[1]};

      s1_valid <= emit;
      if (emit) begin
        s1_ccol <= ccol;
        s1_crow <= crow;
        ccol    <= (ccol == COL_LAST) ? '0 : ccol + CW'(1);
        if (ccol == COL_LAST) crow <= (crow == ROW_LAST) ? '0 : crow + RW'(1);
      end

      pixel_out_valid <= s1_valid;
      if (s1_valid) pixel_out <= (s1_border || !(&win_fg)) ? BG : FG;

      case (state)
        STREAM: begin
          if (transfer) begin
            col <= col_next;
            if (col == COL_LAST) begin
              row <= (row == ROW_LAST) ? '0 : row + RW'(1);
              if (row == ROW_LAST) begin
                state       <= FLUSH;
                pixel_ready <= 1'b0;
                fcnt        <= '0;
              end
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == FLUSH_LAST) begin
            state       <= STREAM;
            pixel_ready <= 1'b1;
          end
        end
        default: begin
          state       <= STREAM;
          pixel_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_erosion_3x3_stream.sv
// Scoreboard bench for erosion_3x3_stream: three instances (5x4 BG=1, 6x6 BG=1, 5x4 BG=0).
module tb_erosion_3x3_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst [3];
  logic       pv  [3];
  logic [7:0] pin [3];
  logic       pr_a, pr_b, pr_c, pov_a, pov_b, pov_c;
  logic [7:0] po_a, po_b, po_c;

  erosion_3x3_stream #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(4), .DATA_WIDTH(8), .BACKGROUND_COLOR(1)) dut_a (
    .clk(clk), .rst(rst[0]), .pixel_valid(pv[0]), .pixel_ready(pr_a), .pixel_in(pin[0]),
    .pixel_out_valid(pov_a), .pixel_out(po_a));
  erosion_3x3_stream #(.IMAGE_WIDTH(6), .IMAGE_HEIGHT(6), .DATA_WIDTH(8), .BACKGROUND_COLOR(1)) dut_b (
    .clk(clk), .rst(rst[1]), .pixel_valid(pv[1]), .pixel_ready(pr_b), .pixel_in(pin[1]),
    .pixel_out_valid(pov_b), .pixel_out(po_b));
  erosion_3x3_stream #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(4), .DATA_WIDTH(8), .BACKGROUND_COLOR(0)) dut_c (
    .clk(clk), .rst(rst[2]), .pixel_valid(pv[2]), .pixel_ready(pr_c), .pixel_in(pin[2]),
    .pixel_out_valid(pov_c), .pixel_out(po_c));

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int stall_cnt = 0;
  int xfer_cyc = 0;
  int t6_cyc = 0;
  int first_out_a = -1;
  logic [7:0] q_a[$], q_b[$], q_c[$];

  // Hand-derived foreground maps of the eroded image, bit c of row r.
  localparam logic [4:0] M54 [4] = '{5'b00000, 5'b01110, 5'b01110, 5'b00000};
  localparam logic [5:0] M66 [6] = '{6'b000000, 6'b010000, 6'b010000,
                                     6'b010000, 6'b011110, 6'b000000};

  function automatic logic [7:0] exp_val(input int sel, input int r, input int c,
                                         input logic [7:0] fg, input logic [7:0] bg);
    logic [4:0] row5;
    logic [5:0] row6;
    logic       is_fg;
    row5 = '0;
    row6 = '0;
    case (sel)
      0: begin row5 = M54[r]; is_fg = row5[c]; end
      1: begin row6 = M66[r]; is_fg = row6[c]; end
      default: begin row5 = M54[r]; is_fg = row5[c] && !(r == 1 && c == 1); end
    endcase
    return is_fg ? fg : bg;
  endfunction

  function automatic logic get_pr(input int d);
    case (d)
      0: return pr_a;
      1: return pr_b;
      default: return pr_c;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    case (d)
      0: q_a.push_back(v);
      1: q_b.push_back(v);
      default: q_c.push_back(v);
    endcase
  endtask

  task automatic mon(input int d, input logic [7:0] v);
    logic [7:0] e;
    int sz;
    sz = (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
    if (sz == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_out dut%0d: got %0d expected no output", d, v);
    end else begin
      case (d)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      chk($sformatf("pixel_out dut%0d", d), int'(v), int'(e));
    end
  endtask

  always @(negedge clk) begin
    if (pov_a) begin
      if (first_out_a < 0) first_out_a = cyc;
      mon(0, po_a);
    end
    if (pov_b) mon(1, po_b);
    if (pov_c) mon(2, po_c);
  end

  task automatic drive_px(input int d, input logic [7:0] v, input int gap_pct);
    int budget;
    budget = 200;
    forever begin
      @(negedge clk);
      if (budget == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drive_timeout dut%0d: ready stayed 0, required 1 within 200 cycles", d);
        return;
      end
      budget--;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        pv[d] = 1'b0;
        continue;
      end
      pv[d]  = 1'b1;
      pin[d] = v;
      if (get_pr(d)) begin
        n_xfer++;
        xfer_cyc = cyc;
        return;
      end
      stall_cnt++;
    end
  endtask

  task automatic drive_frame(input int d, input int w, input int h, input logic [7:0] base,
                             input int sr, input int sc, input logic [7:0] sv, input int sel,
                             input logic [7:0] fg, input logic [7:0] bg, input int gap_pct);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) push(d, exp_val(sel, r, c, fg, bg));
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        drive_px(d, (r == sr && c == sc) ? sv : base, gap_pct);
        if (r * w + c == 6) t6_cyc = xfer_cyc;
      end
  endtask

  task automatic count_ready_low(input int d, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pv[d] = 1'b0;
      if (!get_pr(d)) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      pv[d]  = 1'b0;
      pin[d] = 8'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_valid_a", int'(pov_a), 0);
    chk("reset_out_a", int'(po_a), 255);
    chk("reset_ready_a", int'(pr_a), 1);
    chk("reset_valid_b", int'(pov_b), 0);
    chk("reset_out_b", int'(po_b), 255);
    chk("reset_ready_b", int'(pr_b), 1);
    chk("reset_valid_c", int'(pov_c), 0);
    chk("reset_out_c", int'(po_c), 0);
    chk("reset_ready_c", int'(pr_c), 1);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // All-FG frame, latency of the first output and flush length.
    drive_frame(0, 5, 4, 8'd0, -1, -1, 8'd0, 0, 8'd0, 8'd255, 0);
    chk("first_out_latency", first_out_a, t6_cyc + 2);
    count_ready_low(0, n);
    chk("flush_ready_low", n, 6);

    // Back-to-back frames with valid held high through the flush.
    stall_cnt = 0;
    n_xfer = 0;
    drive_frame(0, 5, 4, 8'd0, -1, -1, 8'd0, 0, 8'd0, 8'd255, 0);
    drive_frame(0, 5, 4, 8'd0, -1, -1, 8'd0, 0, 8'd0, 8'd255, 0);
    chk("b2b_stalls", stall_cnt, 6);
    chk("b2b_transfers", n_xfer, 40);
    count_ready_low(0, n);
    chk("b2b_flush_ready_low", n, 6);

    // Reset after transfer 9: only centres 0..2 (row 0, BG) may appear.
    repeat (3) push(0, 8'd255);
    for (int i = 0; i < 10; i++) drive_px(0, 8'd0, 0);
    @(negedge clk);
    pv[0]  = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("post_reset_valid", int'(pov_a), 0);
    chk("post_reset_ready", int'(pr_a), 1);
    drive_frame(0, 5, 4, 8'd0, -1, -1, 8'd0, 0, 8'd0, 8'd255, 0);
    count_ready_low(0, n);

    // 6x6 with a single BG hole, then the same frame with random gaps.
    drive_frame(1, 6, 6, 8'd0, 2, 2, 8'd255, 1, 8'd0, 8'd255, 0);
    drive_frame(1, 6, 6, 8'd0, 2, 2, 8'd255, 1, 8'd0, 8'd255, 40);
    count_ready_low(1, n);

    // Inverted polarity: FG=255; a 128 pixel at (0,0) counts as background.
    drive_frame(2, 5, 4, 8'd255, -1, -1, 8'd0, 0, 8'd255, 8'd0, 0);
    drive_frame(2, 5, 4, 8'd255, 0, 0, 8'd128, 2, 8'd255, 8'd0, 0);
    count_ready_low(2, n);

    repeat (10) @(negedge clk);
    chk("leftover_expected_a", q_a.size(), 0);
    chk("leftover_expected_b", q_b.size(), 0);
    chk("leftover_expected_c", q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
